reg_state: RTL
==============

Name: reg_state

Overview:
- Architectural register storage plus pending-write scoreboard. Sits directly downstream of the combinational regfile read/bypass block.
- Consumes its per-cycle write-back output (update_register_id / update_register_val) and feeds the registered array back into that block's registers input.
- Adds per-register busy tracking for hazard detection in decode, and a handshaked debug read port.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers (index width = $clog2(NREG)).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- update_register_id  in  5  write-back target; 0 = no write.
- update_register_val  in  XLEN  write-back data.
- registers  out  XLEN x NREG  registered architectural state, unpacked array [NREG-1:0].
- sb_set_valid  in  1  issue of an instruction with a pending destination.
- sb_set_id  in  5  destination being marked busy.
- flush  in  1  pipeline flush; clears every busy bit.
- raddr1, raddr2  in  5  decode source indices for hazard lookup.
- hazard1, hazard2  out  1  source has an unresolved producer.
- busy  out  NREG  busy bit vector.
- dbg_req_valid / dbg_req_ready  in / out  1  debug request handshake.
- dbg_req_id  in  5  register to read.
- dbg_resp_valid / dbg_resp_ready  out / in  1  debug response handshake.
- dbg_resp_data  out  XLEN  debug read value.
- write_count  out  32  committed-write counter; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset (async, rst_n low): registers all 0, busy all 0, dbg_resp_valid 0, dbg_resp_data 0, write_count 0. dbg_req_ready is combinational and reads 1 once reset is deasserted.
- Reset mid-operation: every sequential element clears immediately. An outstanding debug response is dropped.
- Write:
  - On posedge clk with update_register_id != 0, registers[id] <= update_register_val. Visible on registers on the next cycle.
  - id == 0 writes nothing; registers[0] is constant 0.
- Scoreboard:
  - Set: sb_set_valid with sb_set_id != 0 sets busy[id] on the next edge.
  - Clear: a write with update_register_id != 0 clears busy[id].
  - Set and clear to the same id in one cycle: set wins (a newer producer is now outstanding).
  - flush has priority over both: all busy bits become 0 and that cycle's set is ignored.
  - busy[0] is always 0.
- Hazard (combinational): hazardN = busy[raddrN] && !(update_register_id == raddrN && raddrN != 0). A same-cycle write-back resolves the hazard, matching the write-first bypass downstream. raddrN == 0 always gives 0.
- Debug port:
  - dbg_req_ready = !dbg_resp_valid || dbg_resp_ready.
  - Request accepted on valid && ready. Response appears one cycle later: dbg_resp_valid=1, dbg_resp_data = value of registers[id].
  - Same-cycle write to the same id forwards update_register_val (write-first).
  - id 0 returns 0.
  - Response holds stable until dbg_resp_ready. Back-to-back accept and retire in the same cycle sustains one request per cycle.

Optional Feature:
- Macro REG_STATE_WRITE_COUNT_EN.
- Defined:
  - write_count increments by 1 on each cycle with update_register_id != 0.
  - Wraps modulo 2^32; reset to 0.
- Undefined: no counter logic; write_count driven constant 0.

Decomposition:
- Package reg_pkg:
  - XLEN, NREG constants.
  - typedef reg_id_t (logic [4:0]) and word_t (logic [XLEN-1:0]).
  - REG_ZERO constant (5'd0).
- One sub-module, reg_scoreboard: busy vector, set/clear/flush priority and hazard lookup. Storage, debug port and counter live in reg_state.

Test Plan:
- Reset, then write id 5 = 0xDEADBEEF -> registers[5]=0xDEADBEEF next cycle; write id 0 = 0x1234 -> registers[0] stays 0.
- Set busy id 7, raddr1=7 -> hazard1=1; next cycle write id 7 -> hazard1=0 that cycle, busy[7]=0 after the edge.
- Set and write id 9 in the same cycle -> busy[9]=1 after the edge. Set id 9 together with flush -> busy all 0.
- Debug read id 3 while update id 3 = 0xCAFEF00D same cycle -> dbg_resp_data=0xCAFEF00D. Hold dbg_resp_ready=0 for 3 cycles -> dbg_req_ready=0, data stable.
- Assert rst_n low mid debug response and with busy bits set -> dbg_resp_valid, busy, registers all 0 immediately.
- With REG_STATE_WRITE_COUNT_EN: 10 writes including 2 to id 0 -> write_count=8. Without the macro -> write_count=0.

Source files
------------

// File: rtl/reg_state_pkg.sv
// Shared widths, index/word types and the zero-register id for the
// reg_state slice.
package reg_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;

  typedef logic [4:0]      reg_id_t;
  typedef logic [XLEN-1:0] word_t;

  localparam reg_id_t REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write busy vector with hazard lookup for decode.
// Priority on each edge is flush, then issue-set, then write-back clear.
module reg_scoreboard
  import reg_pkg::*;
#(
  parameter int unsigned NREG = reg_pkg::NREG
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sb_set_valid,
  input  reg_id_t         sb_set_id,
  input  logic            flush,
  input  reg_id_t         clr_id,
  input  reg_id_t         raddr1,
  input  reg_id_t         raddr2,
  output logic            hazard1,
  output logic            hazard2,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Set is applied after clear so a newer producer issued in the same
  // cycle as an older write-back keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (clr_id != REG_ZERO) busy_d[clr_id] = 1'b0;
      if (sb_set_valid && (sb_set_id != REG_ZERO)) busy_d[sb_set_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // A same-cycle write-back resolves the hazard through the downstream bypass.
  assign hazard1 = busy_q[raddr1] && !((clr_id == raddr1) && (raddr1 != REG_ZERO));
  assign hazard2 = busy_q[raddr2] && !((clr_id == raddr2) && (raddr2 != REG_ZERO));
  assign busy    = busy_q;

endmodule

// File: rtl/reg_state.sv
// Architectural register storage, busy scoreboard and handshaked debug read.
// Optional committed-write counter enabled by REG_STATE_WRITE_COUNT_EN.
module reg_state
  import reg_pkg::*;
#(
  parameter int unsigned XLEN = reg_pkg::XLEN,
  parameter int unsigned NREG = reg_pkg::NREG
) (
  input  logic            clk,
  input  logic            rst_n,
  input  reg_id_t         update_register_id,
  input  logic [XLEN-1:0] update_register_val,
  output logic [XLEN-1:0] registers [NREG-1:0],
  input  logic            sb_set_valid,
  input  reg_id_t         sb_set_id,
  input  logic            flush,
  input  reg_id_t         raddr1,
  input  reg_id_t         raddr2,
  output logic            hazard1,
  output logic            hazard2,
  output logic [NREG-1:0] busy,
  input  logic            dbg_req_valid,
  output logic            dbg_req_ready,
  input  reg_id_t         dbg_req_id,
  output logic            dbg_resp_valid,
  input  logic            dbg_resp_ready,
  output logic [XLEN-1:0] dbg_resp_data,
  output logic [31:0]     write_count
);

  logic            wr_en;
  logic            dbg_accept;
  logic [XLEN-1:0] dbg_rd_val;

  assign wr_en = (update_register_id != REG_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) registers[i] <= '0;
    end else if (wr_en) begin
      registers[update_register_id] <= update_register_val;
    end
  end

  reg_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .sb_set_valid (sb_set_valid),
    .sb_set_id    (sb_set_id),
    .flush        (flush),
    .clr_id       (update_register_id),
    .raddr1       (raddr1),
    .raddr2       (raddr2),
    .hazard1      (hazard1),
    .hazard2      (hazard2),
    .busy         (busy)
  );

  assign dbg_req_ready = !dbg_resp_valid || dbg_resp_ready;
  assign dbg_accept    = dbg_req_valid && dbg_req_ready;

  // Write-first: a same-cycle write to the requested id is forwarded.
  always_comb begin
    dbg_rd_val = '0;
    if (dbg_req_id == REG_ZERO)                dbg_rd_val = '0;
    else if (update_register_id == dbg_req_id) dbg_rd_val = update_register_val;
    else                                       dbg_rd_val = registers[dbg_req_id];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_resp_valid <= 1'b0;
      dbg_resp_data  <= '0;
    end else if (dbg_accept) begin
      dbg_resp_valid <= 1'b1;
      dbg_resp_data  <= dbg_rd_val;
    end else if (dbg_resp_ready) begin
      dbg_resp_valid <= 1'b0;
    end
  end

`ifdef REG_STATE_WRITE_COUNT_EN
  logic [31:0] write_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     write_count_q <= '0;
    else if (wr_en) write_count_q <= write_count_q + 32'd1;
  end

  assign write_count = write_count_q;
`else
  assign write_count = '0;
`endif

endmodule
